// File: rtl/pll_reset_ctrl_if.sv
// Signal bundle between the PLL reset controller and the PLL / downstream reset tree.
// Level signals only, no handshake: each output is a registered level that is valid every cycle.
interface pll_reset_ctrl_if;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_reset;
  logic       locked_sync;
  logic [3:0] retry_cnt;
  logic [1:0] state;

  modport master (
    input  pll_locked,
    output pll_rst,
    output sys_reset,
    output locked_sync,
    output retry_cnt,
    output state
  );

  modport slave (
    output pll_locked,
    input  pll_rst,
    input  sys_reset,
    input  locked_sync,
    input  retry_cnt,
    input  state
  );
endinterface

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then releases the
// system reset; retries on lock timeout or loss of lock while running.
module pll_reset_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int STABLE_CYCLES = 1024
) (
  input logic               clk,
  input logic               reset,
  pll_reset_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_e;

  localparam int MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_P  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CW     = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          sync1_q;
  logic          sync2_q;
  logic          pll_rst_q;
  logic          sys_reset_q;
  logic [3:0]    retry_q;
  logic [3:0]    retry_d;

  assign retry_d = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.pll_locked;
      sync2_q <= sync1_q;
    end
  end

  // Lock loss is evaluated before any counter expiry so a lost lock never releases or retries early.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= PLL_RST;
      cnt_q       <= '0;
      pll_rst_q   <= 1'b1;
      sys_reset_q <= 1'b1;
      retry_q     <= 4'd0;
    end else begin
      case (state_q)
        PLL_RST: begin
          if (cnt_q == CW'(RST_CYCLES - 1)) begin
            state_q   <= WAIT_LOCK;
            cnt_q     <= '0;
            pll_rst_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (sync2_q) begin
            state_q <= STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
            state_q   <= PLL_RST;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            retry_q   <= retry_d;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STABLE: begin
          if (!sync2_q) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            sys_reset_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (!sync2_q) begin
            state_q     <= PLL_RST;
            cnt_q       <= '0;
            pll_rst_q   <= 1'b1;
            sys_reset_q <= 1'b1;
            retry_q     <= retry_d;
          end
        end
        default: begin
          state_q     <= PLL_RST;
          cnt_q       <= '0;
          pll_rst_q   <= 1'b1;
          sys_reset_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.pll_rst     = pll_rst_q;
  assign bus.sys_reset   = sys_reset_q;
  assign bus.locked_sync = sync2_q;
  assign bus.retry_cnt   = retry_q;
  assign bus.state       = state_q;

endmodule
